// File: rtl/spy_readout_ctrl.sv
// Spy buffer readout controller: gates writes into the spy memory and,
// on a freeze request, dumps the stored words oldest-first over a handshake.
module spy_readout_ctrl #(
  parameter int WIDTH     = 6,
  parameter int DATAWIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spy_write_req,
  input  logic                 freeze_req,
  output logic                 mem_write_enable,
  input  logic [WIDTH-1:0]     mem_write_pointer,
  output logic                 mem_read_enable,
  output logic [WIDTH-1:0]     mem_read_addr,
  input  logic [DATAWIDTH-1:0] mem_read_data,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frozen,
  output logic                 done,
  output logic [15:0]          dropped_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [WIDTH:0]   occupancy;
  logic [WIDTH:0]   remaining;
  logic [WIDTH-1:0] rd_addr;
  logic             xfer;

  assign mem_write_enable = spy_write_req
                          && (state == S_IDLE)
                          && !freeze_req;
  assign xfer = (state == S_PRESENT) && out_ready;
  assign mem_read_addr = rd_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (freeze_req) state_nx = S_FREEZE;
      S_FREEZE:  state_nx = (occupancy == '0) ? S_DONE : S_READ;
      S_READ:    state_nx = S_WAIT;
      S_WAIT:    state_nx = S_PRESENT;
      S_PRESENT: if (out_ready)
                   state_nx = (remaining == ONE) ? S_DONE : S_READ;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_enable = (state == S_READ);
    out_valid       = (state == S_PRESENT);
    out_last        = (state == S_PRESENT) && (remaining == ONE);
    frozen          = (state != S_IDLE);
    done            = (state == S_DONE);
  end

  // Occupancy survives a dump so the same window can be re-read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupancy     <= '0;
      dropped_count <= '0;
    end else begin
      if (mem_write_enable && occupancy != FULL)
        occupancy <= occupancy + ONE;
      if (spy_write_req && !mem_write_enable && dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      remaining <= '0;
      out_data  <= '0;
    end else begin
      if (state == S_FREEZE) begin
        rd_addr   <= mem_write_pointer - occupancy[WIDTH-1:0];
        remaining <= occupancy;
      end
      if (state == S_WAIT)
        out_data <= mem_read_data;
      if (xfer) begin
        rd_addr   <= rd_addr + 1'b1;
        remaining <= remaining - ONE;
      end
    end
  end

endmodule

// File: tb/tb_spy_readout_ctrl.sv
// Bench for spy_readout_ctrl with a modelled 8-entry spy memory
// and a queue-based scoreboard on the readout handshake.
module tb_spy_readout_ctrl;

  localparam int W  = 3;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          spy_write_req = 1'b0;
  logic          freeze_req = 1'b0;
  logic          mem_write_enable;
  logic [W-1:0]  mem_write_pointer;
  logic          mem_read_enable;
  logic [W-1:0]  mem_read_addr;
  logic [DW-1:0] mem_read_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          frozen;
  logic          done;
  logic [15:0]   dropped_count;
  logic [DW-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sb[$];

  spy_readout_ctrl #(.WIDTH(W), .DATAWIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .spy_write_req(spy_write_req),
    .freeze_req(freeze_req),
    .mem_write_enable(mem_write_enable),
    .mem_write_pointer(mem_write_pointer),
    .mem_read_enable(mem_read_enable),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .frozen(frozen),
    .done(done),
    .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [8];
  always @(posedge clock or posedge reset) begin
    if (reset) mem_write_pointer <= '0;
    else if (mem_write_enable) begin
      mem[mem_write_pointer] <= wdata;
      mem_write_pointer      <= mem_write_pointer + 1'b1;
    end
  end
  always @(posedge clock)
    if (mem_read_enable) mem_read_data <= mem[mem_read_addr];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake monitor: out_ready only changes just after posedge.
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", {63'd0, out_last}, {63'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    spy_write_req = 0;
    freeze_req    = 0;
    out_ready     = 1;
    reset         = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      spy_write_req = 1;
      wdata = base + DW'(i);
      tick();
    end
    spy_write_req = 0;
  endtask

  task automatic freeze();
    freeze_req = 1;
    tick();
    freeze_req = 0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    chk({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({name, "_sb_empty"}, DW'(sb.size()), 64'd0);
    tick();
    chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({name, "_frozen_off"}, {63'd0, frozen}, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_frozen", {63'd0, frozen}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd_en", {63'd0, mem_read_enable}, 64'd0);
    chk("rst_rd_addr", DW'(mem_read_addr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_dropped", DW'(dropped_count), 64'd0);
    do_reset();

    // Five words, exact latency to first valid.
    write_words(64'hA0, 5);
    for (int i = 0; i < 5; i++) push(64'hA0 + DW'(i), i == 4);
    freeze();
    chk("t1_frozen_T1", {63'd0, frozen}, 64'd1);
    tick();
    chk("t1_rd_en_T2", {63'd0, mem_read_enable}, 64'd1);
    chk("t1_rd_addr_T2", DW'(mem_read_addr), 64'd0);
    tick();
    chk("t1_rd_en_T3", {63'd0, mem_read_enable}, 64'd0);
    chk("t1_valid_T3", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t1_valid_T4", {63'd0, out_valid}, 64'd1);
    wait_done("t1");

    // Occupancy persists: a second freeze re-dumps the same window.
    for (int i = 0; i < 5; i++) push(64'hA0 + DW'(i), i == 4);
    freeze();
    wait_done("t1b");

    // Wrapped buffer: 11 writes into 8 entries.
    do_reset();
    write_words(64'hD00, 11);
    for (int i = 0; i < 8; i++) push(64'hD03 + DW'(i), i == 7);
    freeze();
    tick();
    chk("t2_start_addr", DW'(mem_read_addr), 64'd3);
    wait_done("t2");

    // Empty dump.
    do_reset();
    freeze();
    chk("t3_frozen_T1", {63'd0, frozen}, 64'd1);
    chk("t3_done_T1", {63'd0, done}, 64'd0);
    tick();
    chk("t3_done_T2", {63'd0, done}, 64'd1);
    chk("t3_valid_T2", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t3_idle_T3", {63'd0, frozen}, 64'd0);

    // Back-pressure on word 2.
    do_reset();
    write_words(64'hB0, 4);
    for (int i = 0; i < 4; i++) push(64'hB0 + DW'(i), i == 3);
    freeze();
    for (int i = 0; i < 5; i++) tick();
    out_ready = 0;
    tick();
    held = out_data;
    chk("t4_word2", held, 64'hB1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("t4_data_hold", out_data, 64'hB1);
      chk("t4_no_read", {63'd0, mem_read_enable}, 64'd0);
      if (i < 3) tick();
    end
    out_ready = 1;
    wait_done("t4");

    // Writes refused on the freeze cycle and during the dump.
    do_reset();
    write_words(64'hC0, 4);
    for (int i = 0; i < 4; i++) push(64'hC0 + DW'(i), i == 3);
    spy_write_req = 1;
    freeze_req = 1;
    #1;
    chk("t5_we_on_freeze", {63'd0, mem_write_enable}, 64'd0);
    tick();
    freeze_req = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_we_frozen", {63'd0, mem_write_enable}, 64'd0);
      tick();
    end
    spy_write_req = 0;
    chk("t5_dropped", DW'(dropped_count), 64'd11);
    wait_done("t5");

    // Reset in WAIT of word 1.
    do_reset();
    write_words(64'hE0, 3);
    freeze();
    tick();
    tick();
    reset = 1;
    #1;
    chk("t6_frozen", {63'd0, frozen}, 64'd0);
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rd_en", {63'd0, mem_read_enable}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    tick();
    chk("t6_done_rst", {63'd0, done}, 64'd0);
    reset = 0;
    freeze();
    chk("t6_frozen_T1", {63'd0, frozen}, 64'd1);
    tick();
    chk("t6_empty_done", {63'd0, done}, 64'd1);
    chk("t6_empty_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t6_idle", {63'd0, frozen}, 64'd0);
    chk("t6_sb_empty", DW'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_readout_ctrl.md
SPY_READOUT_CTRL -- requirements
Module: spy_readout_ctrl

Interface
REQ-001 Parameter WIDTH, default 6: spy memory address width; buffer depth SIZE = 2^WIDTH.
REQ-002 Parameter DATAWIDTH, default 64: spy word width.
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 spy_write_req  in  1  upstream request to store spy_write_data this cycle.
REQ-006 freeze_req  in  1  single-cycle request to freeze the buffer and dump its contents.
REQ-007 mem_write_enable  out  1  write enable to the spy memory.
REQ-008 mem_write_pointer  in  WIDTH  current memory write pointer.
REQ-009 mem_read_enable  out  1  read strobe to the spy memory.
REQ-010 mem_read_addr  out  WIDTH  read address to the spy memory.
REQ-011 mem_read_data  in  DATAWIDTH  memory read result, valid the cycle after mem_read_enable.
REQ-012 out_data  out  DATAWIDTH  dumped word.
REQ-013 out_valid / out_ready  out / in  1 each  readout handshake; a transfer occurs when both are high on a rising edge.
REQ-014 out_last  out  1  high with the final dumped word.
REQ-015 frozen  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of each dump.
REQ-017 dropped_count  out  16  count of spy_write_req cycles refused, saturating at 0xFFFF.

Function
REQ-018 mem_write_enable SHALL be spy_write_req AND (state==IDLE) AND NOT freeze_req, combinationally; a write coincident with freeze_req is dropped.
REQ-019 Occupancy counter (WIDTH+1 bits) SHALL increment on each mem_write_enable, saturating at SIZE; a dump SHALL NOT clear it.
REQ-020 dropped_count SHALL increment on each cycle where spy_write_req=1 and mem_write_enable=0, saturating at 0xFFFF.
REQ-021 States SHALL be IDLE, FREEZE, READ, WAIT, PRESENT, DONE.
REQ-022 IDLE -> FREEZE on freeze_req; freeze_req outside IDLE SHALL be ignored.
REQ-023 FREEZE: latch start address = (mem_write_pointer - occupancy) mod SIZE and remaining = occupancy; go to DONE if occupancy==0, else READ.
REQ-024 READ: assert mem_read_enable for exactly one cycle with mem_read_addr = current address; go to WAIT.
REQ-025 WAIT: register mem_read_data into out_data at the end of the cycle; go to PRESENT.
REQ-026 PRESENT: out_valid=1; out_data stable; out_last=1 iff remaining==1; on transfer decrement remaining, increment address modulo SIZE (wrap SIZE-1 -> 0), go to DONE if remaining becomes 0, else READ.
REQ-027 DONE: done=1 for one cycle; go to IDLE.
REQ-028 mem_read_enable SHALL be 0 outside READ; at most one read outstanding.
REQ-029 out_valid and out_last SHALL be 0 outside PRESENT.
REQ-030 Latency: freeze_req sampled at edge T -> FREEZE in cycle T+1, READ T+2, WAIT T+3, first out_valid T+4; subsequent words 3 cycles apart with out_ready held high.
REQ-031 Words SHALL emerge oldest first, ending with the word at mem_write_pointer-1.
REQ-032 out_ready low in PRESENT SHALL hold state, out_data and out_last unchanged, with no memory reads.

Reset
REQ-033 On reset assertion, immediately: state IDLE, occupancy 0, dropped_count 0, out_data 0, and out_valid, out_last, done, frozen, mem_read_enable, mem_read_addr all 0.
REQ-034 Reset mid-dump SHALL abandon the dump with no done pulse; the memory write pointer is reset alongside this block, consistent with occupancy 0.
REQ-035 Reset deassertion SHALL take effect on the next rising edge; the first freeze_req is honoured at the first edge after deassertion.

Verification (WIDTH=3, SIZE=8)
REQ-036 Write A0..A4, freeze -> out A0..A4, out_last with A4, done one cycle after the A4 transfer, frozen low afterwards.
REQ-037 Write D0..D10 (wraps) -> start addr 3, out D3..D10 (8 words), address wraps 7->0.
REQ-038 Freeze with occupancy 0 -> no out_valid, done at T+2, IDLE at T+3.
REQ-039 out_ready low 4 cycles while word 2 is presented -> out_data held, mem_read_enable stays 0, no loss or duplication.
REQ-040 spy_write_req high on the freeze_req cycle and 10 cycles during the dump -> mem_write_enable 0 throughout, dropped_count=11.
REQ-041 Reset pulse during the WAIT state of word 1 -> all outputs 0 immediately, no done, occupancy 0, new freeze yields empty dump.
